note_scheduler: RTL and testbench

- Sequences the arrow droppers from a chart instead of from per-dropper hard-coded frame delays.
- Reads a note chart (spawn frame, lane) from an external synchronous ROM and claims a free dropper slot from a pool for each note.
- Issues a one-frame spawn command to that slot and tallies the hit/miss pulses the slots return into score and combo.
- Sits between keyboard decode and the dropper pool; its outputs feed the score display.

---
 rtl/rhythm_pkg.sv | 11 +
 rtl/free_slot_picker.sv | 20 ++
 rtl/note_scheduler.sv | 161 ++++++++++++++++
 tb/tb_note_scheduler.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rhythm_pkg.sv
// rhythm_pkg: shared scheduler states, key codes and a popcount helper for note_scheduler.
package rhythm_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, PLAY = 2'd2, DRAIN = 2'd3} sched_state_t;
  localparam logic [7:0] KEY_START = 8'h2c;
  localparam logic [7:0] KEY_ABORT = 8'h29;
  localparam logic [7:0] COMBO_BONUS_THRESH = 8'd10;
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    popcount16 = '0;
    for (int i = 0; i < 16; i++) popcount16 = popcount16 + 5'(v[i]);
  endfunction
endpackage

// File: rtl/free_slot_picker.sv
// free_slot_picker: lowest-index free slot over a busy mask (priority encoder).
module free_slot_picker #(
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_W = 3
) (
  input  logic [NUM_SLOTS-1:0] busy,
  output logic                 found,
  output logic [SLOT_W-1:0]    index
);
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        found = 1'b1;
        index = SLOT_W'(i);
      end
    end
  end
endmodule

// File: rtl/note_scheduler.sv
// note_scheduler: chart-driven dropper sequencer with slot claiming and score/combo tally.
// Define NOTE_SCHED_COMBO_BONUS_EN to double the hit value while combo is at or above the bonus threshold.
module note_scheduler
  import rhythm_pkg::*;
#(
  parameter int NUM_SLOTS  = 8,
  parameter int SLOT_W     = 3,
  parameter int CHART_AW   = 6,
  parameter int TIME_W     = 12,
  parameter int HIT_POINTS = 10
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  input  logic [7:0]           keycode,
  output logic [CHART_AW-1:0]  chart_addr,
  input  logic [TIME_W-1:0]    chart_time,
  input  logic [1:0]           chart_lane,
  input  logic                 chart_last,
  input  logic [NUM_SLOTS-1:0] slot_busy,
  input  logic [NUM_SLOTS-1:0] slot_hit,
  input  logic [NUM_SLOTS-1:0] slot_miss,
  output logic                 spawn_valid,
  output logic [SLOT_W-1:0]    spawn_slot,
  output logic [1:0]           spawn_lane,
  output logic                 overflow_drop,
  output logic [TIME_W-1:0]    frame_count,
  output logic [15:0]          score,
  output logic [7:0]           combo,
  output logic [1:0]           sched_state
);
  sched_state_t state_q, state_d;
  logic done_q, done_d;
  logic [CHART_AW-1:0] chart_addr_q, chart_addr_d;
  logic [TIME_W-1:0] frame_count_q, frame_count_d, frame_inc;
  logic [15:0] score_q, score_d, hit_pts;
  logic [7:0] combo_q, combo_d;
  logic spawn_valid_q, spawn_valid_d, overflow_q, overflow_d;
  logic [SLOT_W-1:0] spawn_slot_q, spawn_slot_d, pick_idx;
  logic [1:0] spawn_lane_q, spawn_lane_d;
  logic [NUM_SLOTS-1:0] claim_q, claim_d;
  logic pick_found, miss_any;
  logic [4:0] hits;
  logic [20:0] score_sum;
  logic [8:0] combo_sum;

  free_slot_picker #(.NUM_SLOTS(NUM_SLOTS), .SLOT_W(SLOT_W)) u_pick (
    .busy  (slot_busy | claim_q),
    .found (pick_found),
    .index (pick_idx)
  );

`ifdef NOTE_SCHED_COMBO_BONUS_EN
  assign hit_pts = combo_q >= COMBO_BONUS_THRESH ? 16'(2 * HIT_POINTS) : 16'(HIT_POINTS);
`else
  assign hit_pts = 16'(HIT_POINTS);
`endif

  // a hit and miss on the same slot in one cycle counts only as a miss
  assign hits      = popcount16(16'(slot_hit & ~slot_miss));
  assign miss_any  = |slot_miss | overflow_q;
  assign score_sum = 21'(score_q) + 21'(hits) * 21'(hit_pts);
  assign combo_sum = 9'(combo_q) + 9'(hits);
  assign frame_inc = &frame_count_q ? frame_count_q : frame_count_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    done_d        = done_q;
    chart_addr_d  = chart_addr_q;
    frame_count_d = frame_count_q;
    score_d       = score_q;
    combo_d       = combo_q;
    spawn_valid_d = 1'b0;
    overflow_d    = 1'b0;
    spawn_slot_d  = spawn_slot_q;
    spawn_lane_d  = spawn_lane_q;
    claim_d       = spawn_valid_q ? NUM_SLOTS'(1) << spawn_slot_q : '0;
    if (state_q != IDLE) begin
      score_d = score_sum > 21'hFFFF ? 16'hFFFF : score_sum[15:0];
      combo_d = miss_any ? 8'd0 : combo_sum > 9'd255 ? 8'hFF : combo_sum[7:0];
    end
    case (state_q)
      IDLE: begin
        chart_addr_d = '0;
        done_d       = 1'b0;
        if (keycode == KEY_START) begin
          frame_count_d = '0;
          score_d       = '0;
          combo_d       = '0;
          state_d       = FETCH;
        end
      end
      FETCH: begin
        frame_count_d = frame_inc;
        state_d       = PLAY;
      end
      PLAY: begin
        frame_count_d = frame_inc;
        if (frame_count_q >= chart_time) begin
          spawn_valid_d = pick_found;
          overflow_d    = !pick_found;
          spawn_slot_d  = pick_idx;
          spawn_lane_d  = chart_lane;
          chart_addr_d  = chart_addr_q + 1'b1;
          state_d       = (chart_last || &chart_addr_q) ? DRAIN : FETCH;
        end
      end
      DRAIN: begin
        // a spawn still in flight has not yet shown up in slot_busy or claim
        if (!done_q) begin
          frame_count_d = frame_inc;
          done_d = slot_busy == '0 && claim_q == '0 && !spawn_valid_q;
        end
      end
    endcase
    if (state_q != IDLE && keycode == KEY_ABORT) begin
      state_d       = IDLE;
      done_d        = 1'b0;
      chart_addr_d  = '0;
      spawn_valid_d = 1'b0;
      overflow_d    = 1'b0;
    end
  end

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= IDLE;
      done_q        <= 1'b0;
      chart_addr_q  <= '0;
      frame_count_q <= '0;
      score_q       <= '0;
      combo_q       <= '0;
      spawn_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
      spawn_slot_q  <= '0;
      spawn_lane_q  <= '0;
      claim_q       <= '0;
    end else begin
      state_q       <= state_d;
      done_q        <= done_d;
      chart_addr_q  <= chart_addr_d;
      frame_count_q <= frame_count_d;
      score_q       <= score_d;
      combo_q       <= combo_d;
      spawn_valid_q <= spawn_valid_d;
      overflow_q    <= overflow_d;
      spawn_slot_q  <= spawn_slot_d;
      spawn_lane_q  <= spawn_lane_d;
      claim_q       <= claim_d;
    end
  end

  assign chart_addr    = chart_addr_q;
  assign spawn_valid   = spawn_valid_q;
  assign spawn_slot    = spawn_slot_q;
  assign spawn_lane    = spawn_lane_q;
  assign overflow_drop = overflow_q;
  assign frame_count   = frame_count_q;
  assign score         = score_q;
  assign combo         = combo_q;
  assign sched_state   = state_q;
endmodule

// File: tb/tb_note_scheduler.sv
// tb_note_scheduler: directed bench for note_scheduler with a registered chart ROM model.
// Stimulus is driven and outputs sampled on the falling edge of frame_clk.
module tb_note_scheduler;
  logic frame_clk = 1'b0, Reset = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic [5:0] chart_addr;
  logic [11:0] chart_time, frame_count;
  logic [1:0] chart_lane, spawn_lane, sched_state;
  logic chart_last, spawn_valid, overflow_drop;
  logic [7:0] slot_busy = '0, slot_hit = '0, slot_miss = '0, combo;
  logic [2:0] spawn_slot;
  logic [15:0] score;
  logic [14:0] mem [64];
  int n_chk = 0, n_fail = 0;

`ifdef NOTE_SCHED_COMBO_BONUS_EN
  localparam int BONUS = 20;
`else
  localparam int BONUS = 10;
`endif

  typedef struct {
    logic [7:0] hit;
    logic [7:0] miss;
    int score;
    int combo;
  } tv_t;
  tv_t tv [9];

  note_scheduler dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .chart_addr(chart_addr),
    .chart_time(chart_time), .chart_lane(chart_lane), .chart_last(chart_last),
    .slot_busy(slot_busy), .slot_hit(slot_hit), .slot_miss(slot_miss),
    .spawn_valid(spawn_valid), .spawn_slot(spawn_slot), .spawn_lane(spawn_lane),
    .overflow_drop(overflow_drop), .frame_count(frame_count), .score(score),
    .combo(combo), .sched_state(sched_state)
  );

  always #5 frame_clk = ~frame_clk;
  always @(posedge frame_clk) {chart_time, chart_lane, chart_last} <= mem[chart_addr];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge frame_clk);
  endtask

  task automatic start();
    keycode = 8'h2c;
    tick();
    keycode = 8'h00;
  endtask

  task automatic abort();
    keycode = 8'h29;
    tick();
    keycode = 8'h00;
  endtask

  initial begin
    int cyc;
    tv[0] = '{8'h05, 8'h00, 20, 2};
    tv[1] = '{8'h01, 8'h02, 30, 0};
    tv[2] = '{8'h03, 8'h03, 30, 0};
    tv[3] = '{8'hFF, 8'h00, 110, 8};
    tv[4] = '{8'h04, 8'h00, 120, 9};
    tv[5] = '{8'h01, 8'h00, 130, 10};
    tv[6] = '{8'h01, 8'h00, 130 + BONUS, 11};
    tv[7] = '{8'h00, 8'h80, 130 + BONUS, 0};
    tv[8] = '{8'h00, 8'h00, 130 + BONUS, 0};
    for (int i = 0; i < 64; i++) mem[i] = '0;
    tick(2);
    check("rst_spawn_valid", spawn_valid, 0);
    check("rst_state", sched_state, 0);
    check("rst_addr", chart_addr, 0);
    check("rst_frame", frame_count, 0);
    check("rst_score", score, 0);
    check("rst_combo", combo, 0);
    check("rst_overflow", overflow_drop, 0);
    Reset = 1'b1;
    tick(2);

    // start and spawn, claim mask forces the second note onto slot 1
    mem[0] = {12'd5, 2'd2, 1'b0};
    mem[1] = {12'd5, 2'd1, 1'b1};
    start();
    check("t1_fetch", sched_state, 1);
    check("t1_frame0", frame_count, 0);
    tick(5);
    check("t1_play", sched_state, 2);
    check("t1_no_early_spawn", spawn_valid, 0);
    tick();
    check("t1_spawn0_valid", spawn_valid, 1);
    check("t1_spawn0_slot", spawn_slot, 0);
    check("t1_spawn0_lane", spawn_lane, 2);
    check("t1_addr1", chart_addr, 1);
    tick();
    check("t1_gap", spawn_valid, 0);
    tick();
    check("t1_spawn1_valid", spawn_valid, 1);
    check("t1_spawn1_slot", spawn_slot, 1);
    check("t1_spawn1_lane", spawn_lane, 1);
    check("t1_drain", sched_state, 3);
    slot_busy = 8'h03;
    tick(4);
    check("t1_drain_counting", frame_count, 12);
    slot_busy = 8'h00;
    tick(3);
    check("t1_done_hold", frame_count, 13);

    // tally table applied in DONE
    for (int i = 0; i < 9; i++) begin
      slot_hit = tv[i].hit;
      slot_miss = tv[i].miss;
      tick();
      check($sformatf("tally%0d_score", i), score, tv[i].score);
      check($sformatf("tally%0d_combo", i), combo, tv[i].combo);
    end
    slot_miss = 8'h00;
    slot_hit = 8'hFF;
    tick(900);
    check("sat_score", score, 16'hFFFF);
    check("sat_combo", combo, 255);
    slot_hit = 8'h01;
    tick();
    check("sat_score_hold", score, 16'hFFFF);
    check("sat_combo_hold", combo, 255);
    slot_hit = 8'h00;
    check("done_frame_held", frame_count, 13);
    abort();
    check("done_abort_state", sched_state, 0);
    check("done_abort_addr", chart_addr, 0);
    check("idle_score_kept", score, 16'hFFFF);

    // overflow, then abort coinciding with a due note
    mem[0] = {12'd5, 2'd3, 1'b0};
    mem[1] = {12'd9, 2'd1, 1'b1};
    start();
    check("ovf_start_clears_score", score, 0);
    slot_hit = 8'h7F;
    tick();
    slot_hit = 8'h00;
    slot_busy = 8'hFF;
    check("ovf_combo7", combo, 7);
    tick(5);
    check("ovf_pulse", overflow_drop, 1);
    check("ovf_no_spawn", spawn_valid, 0);
    check("ovf_addr", chart_addr, 1);
    check("ovf_combo_before", combo, 7);
    slot_busy = 8'h00;
    tick();
    check("ovf_pulse_end", overflow_drop, 0);
    check("ovf_combo_cleared", combo, 0);
    tick(2);
    check("abort_pre_state", sched_state, 2);
    check("abort_pre_frame", frame_count, 9);
    abort();
    check("abort_state", sched_state, 0);
    check("abort_no_spawn", spawn_valid, 0);
    check("abort_no_ovf", overflow_drop, 0);
    check("abort_addr", chart_addr, 0);
    check("abort_score_kept", score, 70);
    tick();
    check("abort_still_no_spawn", spawn_valid, 0);

    // chart exhaustion without a last flag
    for (int i = 0; i < 64; i++) mem[i] = '0;
    start();
    tick(2);
    check("exh_first_slot", spawn_slot, 0);
    tick(2);
    check("exh_second_slot", spawn_slot, 1);
    tick(123);
    check("exh_play63", sched_state, 2);
    check("exh_addr63", chart_addr, 63);
    tick();
    check("exh_drain", sched_state, 3);
    check("exh_addr_wrap", chart_addr, 0);
    abort();

    // frame counter saturation
    mem[0] = {12'd4095, 2'd3, 1'b1};
    start();
    cyc = 1;
    while (!spawn_valid && cyc < 5000) begin
      tick();
      cyc++;
    end
    check("fsat_spawn_seen", spawn_valid, 1);
    check("fsat_spawn_cycle", cyc, 4097);
    check("fsat_lane", spawn_lane, 3);
    check("fsat_frame", frame_count, 4095);
    tick(3);
    check("fsat_frame_hold", frame_count, 4095);
    abort();

    // asynchronous reset during a spawn
    mem[0] = {12'd5, 2'd2, 1'b1};
    start();
    slot_hit = 8'h01;
    tick();
    slot_hit = 8'h00;
    check("ar_score_pre", score, 10);
    tick(5);
    check("ar_spawn_pre", spawn_valid, 1);
    #2 Reset = 1'b0;
    #1;
    check("ar_spawn_valid", spawn_valid, 0);
    check("ar_lane", spawn_lane, 0);
    check("ar_state", sched_state, 0);
    check("ar_frame", frame_count, 0);
    check("ar_score", score, 0);
    check("ar_addr", chart_addr, 0);
    tick();
    Reset = 1'b1;
    tick();
    check("ar_idle_after", sched_state, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
